// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for the iterative InvMixColumns engine: input state channel,
// result channel and a busy indicator.
interface inv_mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one 128-bit state per handshake, COLS_PER_CYCLE
// columns transformed per clock, result held until the consumer takes it.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  inv_mix_columns_iter_if.slave bus
);

  // Column step wraps the 2-bit counter; with 4 columns per cycle the step is 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg;
  logic [1:0]   col_reg;
  logic [127:0] work_reg;
  logic [127:0] work_next;
  logic [127:0] out_state_reg;
  logic         out_valid_reg;
  logic         busy_reg;

  logic [1:0]   grp_col [COLS_PER_CYCLE];
  logic [31:0]  grp_in  [COLS_PER_CYCLE];
  logic [31:0]  grp_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    // 0E = x8^x4^x2, 0B = x8^x2^1, 0D = x8^x4^1, 09 = x8^1
    for (int k = 0; k < 4; k++) begin
      r[31-8*k -: 8] = (x8[k]       ^ x4[k]       ^ x2[k])
                     ^ (x8[(k+1)%4] ^ x2[(k+1)%4] ^ a[(k+1)%4])
                     ^ (x8[(k+2)%4] ^ x4[(k+2)%4] ^ a[(k+2)%4])
                     ^ (x8[(k+3)%4] ^ a[(k+3)%4]);
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
      assign grp_col[gi] = col_reg + 2'(gi);
      assign grp_in[gi]  = work_reg[7'd127 - {grp_col[gi], 5'd0} -: 32];
      assign grp_out[gi] = inv_col(grp_in[gi]);
    end
  endgenerate

  always_comb begin
    work_next = work_reg;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[7'd127 - {grp_col[g], 5'd0} -: 32] = grp_out[g];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_reg       <= 2'd0;
      work_reg      <= '0;
      out_state_reg <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            work_reg  <= bus.in_state;
            col_reg   <= 2'd0;
            busy_reg  <= 1'b1;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          work_reg <= work_next;
          col_reg  <= col_reg + COL_STEP;
          if (col_reg == LAST_COL) begin
            out_state_reg <= work_next;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_state = out_state_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter: FIPS vector, backpressure, reset
// mid-operation, back-to-back streaming and a forward/inverse round trip at 1/2/4 columns per cycle.
module tb_inv_mix_columns_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter_if if_c1 ();
  inv_mix_columns_iter_if if_c2 ();
  inv_mix_columns_iter_if if_c4 ();

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst(rst), .bus(if_c1.slave));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst(rst), .bus(if_c2.slave));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst(rst), .bus(if_c4.slave));

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] ONES     = 128'h01010101_01010101_01010101_01010101;

  // Forward MixColumns, used to build inputs whose inverse is known
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
      r[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (if_c1.in_ready !== 1'b0 || if_c1.out_valid !== 1'b0 || if_c1.busy !== 1'b0 || if_c1.out_state !== '0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_state=%h, required 0 0 0 0",
               if_c1.in_ready, if_c1.out_valid, if_c1.busy, if_c1.out_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if_c1.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_in_ready: got %b required 1", if_c1.in_ready);
    end
    $display("reset: done");
  endtask

  task automatic test_fips();
    int lat;
    if_c1.out_ready = 1'b0;
    if_c1.in_valid  = 1'b1;
    if_c1.in_state  = FIPS_IN;
    @(negedge clk);
    // Input stays valid with junk while busy; it must be ignored
    if_c1.in_state = 128'hdeadbeef_00112233_44556677_8899aabb;
    checks++;
    if (if_c1.busy !== 1'b1 || if_c1.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fips_busy: busy=%b in_ready=%b required 1 0", if_c1.busy, if_c1.in_ready);
    end
    lat = 0;
    while (if_c1.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL fips_latency: got %0d cycles required 4", lat);
    end
    checks++;
    if (if_c1.out_state !== FIPS_OUT) begin
      fails++;
      $display("FAIL fips_value: got %h required %h", if_c1.out_state, FIPS_OUT);
    end
    $display("fips: out_state=%h latency=%0d", if_c1.out_state, lat);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      if_c1.in_valid = 1'b1;
      if_c1.in_state = {4{$urandom}};
      @(negedge clk);
      checks++;
      if (if_c1.out_valid !== 1'b1 || if_c1.out_state !== FIPS_OUT || if_c1.in_ready !== 1'b0 || if_c1.busy !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold[%0d]: ov=%b os=%h ir=%b busy=%b required 1 %h 0 0",
                 i, if_c1.out_valid, if_c1.out_state, if_c1.in_ready, if_c1.busy, FIPS_OUT);
      end
    end
    if_c1.in_valid  = 1'b0;
    if_c1.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_c1.out_valid !== 1'b0 || if_c1.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1", if_c1.out_valid, if_c1.in_ready);
    end
    @(negedge clk);
    checks++;
    if (if_c1.busy !== 1'b0 || if_c1.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_no_accept: busy=%b out_valid=%b required 0 0", if_c1.busy, if_c1.out_valid);
    end
    $display("backpressure: held 10 cycles, released");
  endtask

  task automatic test_reset_mid_op();
    int lat;
    if_c1.out_ready = 1'b1;
    if_c1.in_valid  = 1'b1;
    if_c1.in_state  = 128'h00112233_44556677_8899aabb_ccddeeff;
    @(negedge clk);
    if_c1.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if_c1.out_valid !== 1'b0 || if_c1.out_state !== '0 || if_c1.busy !== 1'b0 || if_c1.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: ov=%b os=%h busy=%b ir=%b required 0 0 0 0",
               if_c1.out_valid, if_c1.out_state, if_c1.busy, if_c1.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (if_c1.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_in_ready: got %b required 1", if_c1.in_ready);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (if_c1.out_valid !== 1'b0 || if_c1.busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_ghost: out_valid=%b busy=%b required 0 0", if_c1.out_valid, if_c1.busy);
    end
    if_c1.in_valid = 1'b1;
    if_c1.in_state = ONES;
    @(negedge clk);
    if_c1.in_valid = 1'b0;
    lat = 0;
    while (if_c1.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || if_c1.out_state !== ONES) begin
      fails++;
      $display("FAIL midreset_next: latency=%0d out_state=%h required 4 %h", lat, if_c1.out_state, ONES);
    end
    @(negedge clk);
    $display("reset_mid_op: next state out=%h", ONES);
  endtask

  task automatic test_back_to_back();
    logic [127:0] stim [4];
    logic [127:0] expv [4];
    logic [127:0] val;
    logic acc, take;
    int idx, got, cyc, last;
    stim[0] = '0;        expv[0] = '0;
    stim[1] = FIPS_IN;   expv[1] = FIPS_OUT;
    expv[2] = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0; stim[2] = fwd_mix(expv[2]);
    expv[3] = 128'hffffffff_80402010_01020408_a5a5a5a5; stim[3] = fwd_mix(expv[3]);
    @(negedge clk);
    if_c1.out_ready = 1'b1;
    if_c1.in_valid  = 1'b1;
    if_c1.in_state  = stim[0];
    idx = 0; got = 0; cyc = 0; last = -1;
    while (got < 4 && cyc < 100) begin
      acc  = if_c1.in_valid && if_c1.in_ready;
      take = if_c1.out_valid && if_c1.out_ready;
      val  = if_c1.out_state;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 6) begin
            fails++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles required 6", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 4) if_c1.in_state = stim[idx];
        else if_c1.in_valid = 1'b0;
      end
      if (take) begin
        checks++;
        if (got >= 4 || val !== expv[got]) begin
          fails++;
          $display("FAIL b2b_result[%0d]: got %h required %h", got, val, expv[got]);
        end
        $display("b2b: result %0d = %h", got, val);
        got++;
      end
    end
    checks++;
    if (got !== 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d results required 4 (timeout)", got);
    end
    if_c1.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [127:0] s, f;
    logic [2:0] done;
    int lat, bad;
    bad = 0;
    for (int it = 0; it < 1000; it++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      f = fwd_mix(s);
      @(negedge clk);
      if_c1.in_valid = 1'b1; if_c2.in_valid = 1'b1; if_c4.in_valid = 1'b1;
      if_c1.in_state = f;    if_c2.in_state = f;    if_c4.in_state = f;
      if_c1.out_ready = 1'b1; if_c2.out_ready = 1'b1; if_c4.out_ready = 1'b1;
      @(negedge clk);
      if_c1.in_valid = 1'b0; if_c2.in_valid = 1'b0; if_c4.in_valid = 1'b0;
      done = 3'b000;
      lat = 0;
      while (done !== 3'b111 && lat < 12) begin
        @(negedge clk);
        lat++;
        if (!done[0] && if_c1.out_valid === 1'b1) begin
          done[0] = 1'b1;
          checks++;
          if (if_c1.out_state !== s || lat !== 4) begin
            fails++; bad++;
            $display("FAIL round_trip_c1[%0d]: got %h lat %0d required %h lat 4", it, if_c1.out_state, lat, s);
          end
        end
        if (!done[1] && if_c2.out_valid === 1'b1) begin
          done[1] = 1'b1;
          checks++;
          if (if_c2.out_state !== s || lat !== 2) begin
            fails++; bad++;
            $display("FAIL round_trip_c2[%0d]: got %h lat %0d required %h lat 2", it, if_c2.out_state, lat, s);
          end
        end
        if (!done[2] && if_c4.out_valid === 1'b1) begin
          done[2] = 1'b1;
          checks++;
          if (if_c4.out_state !== s || lat !== 1) begin
            fails++; bad++;
            $display("FAIL round_trip_c4[%0d]: got %h lat %0d required %h lat 1", it, if_c4.out_state, lat, s);
          end
        end
      end
      if (done !== 3'b111) begin
        checks++; fails++;
        $display("FAIL round_trip_timeout[%0d]: done mask %b required 111", it, done);
        break;
      end
    end
    $display("round_trip: 1000 states x 3 widths, %0d mismatching", bad);
  endtask

  initial begin
    if_c1.in_valid = 1'b0; if_c1.in_state = '0; if_c1.out_ready = 1'b0;
    if_c2.in_valid = 1'b0; if_c2.in_state = '0; if_c2.out_ready = 1'b0;
    if_c4.in_valid = 1'b0; if_c4.in_state = '0; if_c4.out_ready = 1'b0;
    test_reset();
    test_fips();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
